booth_multiplier_core: RTL and testbench
========================================

Name: booth_multiplier_core

Overview:
Sequential radix-2 Booth signed multiplier datapath and control. It sits directly downstream of the Booth recode decoder:
- Each cycle it presents the current {Q[0], Q_-1} bit pair to the decoder.
- It consumes the decoder's op / shift_op result to add, subtract or skip the multiplicand, then arithmetic-shifts the partial product.
- It produces a 2*WORD_LENGTH-bit signed product after WORD_LENGTH iterations.

Parameters:
- WORD_LENGTH, 16, operand width in bits; two's complement; legal range 4..32.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  request to begin; sampled only in IDLE.
- multiplicand  input  WORD_LENGTH  signed operand M; captured on the accepted start.
- multiplier  input  WORD_LENGTH  signed operand Q; captured on the accepted start.
- q_pair  output  2  {Q[0], Q_-1} driven to the decoder; combinational from registers.
- op  input  1  from decoder: 1 = add M, 0 = subtract M (valid when shift_op = 0).
- shift_op  input  1  from decoder: 1 = shift only; op is ignored.
- busy  output  1  high in CALC.
- done  output  1  single-cycle pulse in DONE.
- product  output  2*WORD_LENGTH  signed result; held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, product=0, q_pair=2'b00. State=IDLE; A, Q, Q_-1 and count all cleared.
- Internal registers:
  - A is WORD_LENGTH+1 bits (one guard bit, so M = -2^(WORD_LENGTH-1) does not overflow).
  - Q is WORD_LENGTH bits; Q_-1 is 1 bit.
  - M_reg is sign-extended to WORD_LENGTH+1 bits.
  - count is clog2(WORD_LENGTH)+1 bits.
- IDLE: when start=1 at a clock edge, load A=0, Q=multiplier, Q_-1=0, M_reg=sext(multiplicand), count=WORD_LENGTH, and go to CALC. product is not altered.
- CALC (one iteration per cycle; busy=1):
  - A_t = A when shift_op=1; A+M_reg when shift_op=0 and op=1; A-M_reg when shift_op=0 and op=0.
  - Arithmetic right shift of {A_t, Q, Q_-1} by 1; the MSB of A_t is replicated.
  - count decrements by 1.
  - The iteration in which count reaches 1 is the last one: product <= lower 2*WORD_LENGTH bits of the shifted {A, Q}, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: start accepted at edge 0; done is high in the cycle following edge WORD_LENGTH. product is valid from that same edge onward.
- start while in CALC or DONE: ignored, with no queuing.
- Decoder inputs are used in the same cycle q_pair is driven (zero-latency combinational loop through the decoder). The decoder must stay purely combinational.
- shift_op=1 overrides op regardless of op's value.
- Reset asserted mid-operation: immediately returns to reset values. The partial result is discarded and no done pulse is generated.
- Operands changing after start is accepted have no effect.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined: on an accepted start where multiplicand==0 or multiplier==0:
  - Skip CALC and go directly to DONE with product=0.
  - done is high in the cycle after edge 0 (latency 1).
  - busy stays 0.
- Not defined: zero operands take the full WORD_LENGTH iterations like any other operands and produce 0.

Test Plan:
- WORD_LENGTH=16, M=3, Q=5, start pulse -> busy for 16 cycles, done pulse once, product=32'd15.
- M=-7, Q=6 -> product=32'hFFFF_FFD6 (-42); q_pair sequence on the first 3 iterations = 00, 10, 11.
- M=16'h8000, Q=16'h8000 -> product=32'h4000_0000; M=16'h8000, Q=16'h7FFF -> product=32'hC000_8000.
- M=0, Q=1234 -> product=0. Latency is 16 cycles without BOOTH_ZERO_SKIP_EN and 1 cycle with it.
- Second start pulsed 5 cycles into CALC with different operands -> ignored; the first result, 15, is delivered. A start in the cycle after done -> accepted.
- reset driven low 8 cycles into CALC -> busy=0, done=0, product=0 immediately; no done pulse until a new start.

Source files
------------

// File: rtl/booth_multiplier_core.sv
// Sequential radix-2 Booth signed multiplier: one add/sub/skip plus arithmetic shift per cycle,
// steered by an external combinational recode decoder. Define BOOTH_ZERO_SKIP_EN to bypass zero operands.
module booth_multiplier_core #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic [1:0]                 q_pair,
  input  logic                       op,
  input  logic                       shift_op,
  output logic                       busy,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   product
);

  localparam int AW = WORD_LENGTH + 1;
  localparam int CW = $clog2(WORD_LENGTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            a_q, a_d;
  logic [AW-1:0]            m_q, m_d;
  logic [WORD_LENGTH-1:0]   q_q, q_d;
  logic                     qm1_q, qm1_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [2*WORD_LENGTH-1:0] product_q, product_d;

  logic [AW-1:0]            a_t_s;
  logic [AW-1:0]            a_sh_s;
  logic [WORD_LENGTH-1:0]   q_sh_s;

  assign q_pair  = {q_q[0], qm1_q};
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  // Iteration datapath: decoder-selected add/sub/skip, then arithmetic shift of {A, Q, Q_-1}
  always_comb begin
    a_t_s = a_q;
    if (shift_op) begin
      a_t_s = a_q;
    end else if (op) begin
      a_t_s = a_q + m_q;
    end else begin
      a_t_s = a_q - m_q;
    end
    a_sh_s = {a_t_s[AW-1], a_t_s[AW-1:1]};
    q_sh_s = {a_t_s[0], q_q[WORD_LENGTH-1:1]};
  end

  // Control FSM next-state and register updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = {AW{1'b0}};
          q_d     = multiplier;
          qm1_d   = 1'b0;
          m_d     = {multiplicand[WORD_LENGTH-1], multiplicand};
          count_d = CW'(WORD_LENGTH);
`ifdef BOOTH_ZERO_SKIP_EN
          if ((multiplicand == {WORD_LENGTH{1'b0}}) || (multiplier == {WORD_LENGTH{1'b0}})) begin
            product_d = {(2*WORD_LENGTH){1'b0}};
            state_d   = S_DONE;
          end else begin
            state_d   = S_CALC;
          end
`else
          state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        a_d     = a_sh_s;
        q_d     = q_sh_s;
        qm1_d   = q_q[0];
        count_d = count_q - CW'(1);
        // Lower 2*WORD_LENGTH bits of the shifted {A, Q}; the guard bit is dropped
        if (count_q == CW'(1)) begin
          product_d = {a_sh_s[WORD_LENGTH-1:0], q_sh_s};
          state_d   = S_DONE;
        end else begin
          state_d   = S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= {AW{1'b0}};
      m_q       <= {AW{1'b0}};
      q_q       <= {WORD_LENGTH{1'b0}};
      qm1_q     <= 1'b0;
      count_q   <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {(2*WORD_LENGTH){1'b0}};
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier_core.sv
// Randomized self-checking bench for booth_multiplier_core with an in-bench Booth decoder
// and a latency/product reference model based on plain signed multiplication.
module tb_booth_multiplier_core;

  localparam int W = 16;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [1:0]     q_pair;
  logic           op;
  logic           shift_op;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           noise = 1'b0;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  booth_multiplier_core #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .q_pair(q_pair), .op(op), .shift_op(shift_op),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // Booth recode decoder; op is random whenever shift_op makes it irrelevant
  assign shift_op = (q_pair[1] == q_pair[0]);
  assign op       = shift_op ? noise : (q_pair == 2'b01);

  always @(negedge clk) noise <= 1'($urandom);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [W-1:0]   ms;
    logic signed [W-1:0]   qs;
    logic signed [2*W-1:0] p;
    ms = m;
    qs = q;
    p  = ms * qs;
    return p;
  endfunction

  // Reference model: W busy cycles then one done cycle, product = M*Q
  int             mdl_left = 0;
  bit             mdl_done = 1'b0;
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic [2*W-1:0] exp_product = '0;
  logic [2*W-1:0] pend = '0;
  logic [W-1:0]   mdl_q = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_left <= 0; mdl_done <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b0; exp_product <= '0;
    end else if (mdl_done) begin
      mdl_done <= 1'b0; exp_done <= 1'b0;
    end else if (mdl_left > 0) begin
      mdl_left <= mdl_left - 1;
      if (mdl_left == 1) begin
        exp_busy <= 1'b0; exp_done <= 1'b1; mdl_done <= 1'b1; exp_product <= pend;
      end
    end else if (start) begin
      pend  <= mul_ref(multiplicand, multiplier);
      mdl_q <= multiplier;
      if (ZS && (multiplicand == '0 || multiplier == '0)) begin
        exp_done <= 1'b1; mdl_done <= 1'b1; exp_product <= '0;
      end else begin
        mdl_left <= W; exp_busy <= 1'b1;
      end
    end
  end

  // Per-cycle comparison; iteration i presents {Q[i], Q[i-1]} with Q[-1] = 0
  always @(negedge clk) begin : cmp
    int         iter;
    logic [W:0] qx;
    if (cmp_en) begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("product", product, exp_product);
      if (exp_busy) begin
        iter = W - mdl_left;
        qx   = {mdl_q, 1'b0};
        chk("q_pair", q_pair, {qx[iter+1], qx[iter]});
      end
    end
  end

  logic [1:0] qp_log [0:63];

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int inj_at,
                        output int lat, output int bc);
    @(negedge clk);
    multiplicand = m; multiplier = q; start = 1'b1;
    lat = 0; bc = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      start = (lat == inj_at);
      multiplicand = W'($urandom); multiplier = W'($urandom);
      if (busy) begin
        qp_log[bc] = q_pair;
        bc++;
      end
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
  endtask

  int lat, bc, dcnt;
  logic [W-1:0] rm, rq;

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_product", product, 32'd0);
    chk("rst_q_pair", q_pair, 2'b00);
    #2 reset = 1'b1;
    cmp_en = 1'b1;

    run_op(16'd3, 16'd5, -1, lat, bc);
    chk("p_3x5", product, 32'd15);
    chk("lat_3x5", lat, W + 1);
    chk("busy_3x5", bc, W);

    run_op(16'hFFF9, 16'd6, -1, lat, bc);
    chk("p_m7x6", product, 32'hFFFF_FFD6);
    chk("qp0", qp_log[0], 2'b00);
    chk("qp1", qp_log[1], 2'b10);
    chk("qp2", qp_log[2], 2'b11);

    run_op(16'h8000, 16'h8000, -1, lat, bc);
    chk("p_min_min", product, 32'h4000_0000);
    run_op(16'h8000, 16'h7FFF, -1, lat, bc);
    chk("p_min_max", product, 32'hC000_8000);

    run_op(16'd0, 16'd1234, -1, lat, bc);
    chk("p_zero", product, 32'd0);
    chk("lat_zero", lat, ZS ? 1 : W + 1);
    chk("busy_zero", bc, ZS ? 0 : W);

    // Second start mid-CALC is ignored; the next start right after done is accepted
    run_op(16'd3, 16'd5, 6, lat, bc);
    chk("p_ignored_start", product, 32'd15);
    chk("lat_ignored_start", lat, W + 1);
    run_op(16'd100, 16'hFFFE, -1, lat, bc);
    chk("p_after_done", product, 32'hFFFF_FF38);

    // Reset mid-CALC
    @(negedge clk);
    multiplicand = 16'd11; multiplier = 16'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_product", product, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);

    repeat (40) begin
      rm = W'($urandom);
      rq = W'($urandom);
      if ($urandom_range(0, 7) == 0) rm = '0;
      if ($urandom_range(0, 7) == 0) rq = '0;
      run_op(rm, rq, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 2)) : -1, lat, bc);
      chk("p_rand", product, mul_ref(rm, rq));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
